// File: rtl/_piso_er_pkg.sv
// Shared constants for the serial word blocks (piso/sipo pair).
package _piso_er_pkg;

   localparam int WORD_LENGTH = 8;

   localparam logic [0:0] SER_IDLE  = 1'b0;
   localparam logic [0:0] SER_SHIFT = 1'b1;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/_piso_er_if.sv
// Load handshake plus serial output handshake for the parallel-in/serial-out block.
interface _piso_er_if
   import _piso_er_pkg::*;
#(
   parameter int N = WORD_LENGTH
);
   logic         ld_valid;
   logic         ld_ready;
   logic [N-1:0] D;
   logic         sout;
   logic         sout_valid;
   logic         sout_ready;
   logic         busy;
   logic         done;

   modport master (
      output ld_valid, D, sout_ready,
      input  ld_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  ld_valid, D, sout_ready,
      output ld_ready, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/_dff_er.sv
// W-bit register with enable and asynchronous active-high clear.
module _dff_er #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (en) data_d = d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign q = data_q;
endmodule

// File: rtl/_piso_er.sv
// Parallel-in/serial-out: loads a word on the ld handshake, drains it one bit per
// accepted serial beat, and reloads on the last beat so words stream without a bubble.
//
//   state     | meaning
//   SER_IDLE  | no word held, sout_valid low, ready to load
//   SER_SHIFT | word in flight, sout presents the current bit
module _piso_er
   import _piso_er_pkg::*;
#(
   parameter int n         = WORD_LENGTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   _piso_er_if.slave   io
);
   localparam int            CW       = cnt_width(n);
   localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          done_q,  done_d;
   logic [n-1:0]  sreg_q,  sreg_d;
   logic          sreg_en;

   logic sout_valid;
   logic ld_ready;
   logic load;
   logic beat;
   logic last;
   logic sout_bit;

   always_comb begin
      sout_valid = (state_q == SER_SHIFT);
      beat       = sout_valid & io.sout_ready;
      last       = beat & (cnt_q == CNT_LAST);
      ld_ready   = (state_q == SER_IDLE) | last;
      load       = io.ld_valid & ld_ready;
   end

   // Shift fills with zero, so a drained register is already clear on return to idle.
   always_comb begin
      sreg_en = load | beat;
      if (load)           sreg_d = io.D;
      else if (MSB_FIRST) sreg_d = sreg_q << 1;
      else                sreg_d = sreg_q >> 1;
   end

   _dff_er #(.W(n)) u_sreg (
      .clk (clk),
      .rst (rst),
      .en  (sreg_en),
      .d   (sreg_d),
      .q   (sreg_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == SER_IDLE) begin
         if (load) begin
            state_d = SER_SHIFT;
            cnt_d   = '0;
         end
      end else begin
         if (last) begin
            cnt_d = '0;
            if (!load) state_d = SER_IDLE;
         end else if (beat) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      done_d = last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SER_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      sout_bit      = MSB_FIRST ? sreg_q[n-1] : sreg_q[0];
      io.sout       = sout_valid & sout_bit;
      io.sout_valid = sout_valid;
      io.busy       = sout_valid;
      io.done       = done_q;
      io.ld_ready   = ld_ready;
   end
endmodule

// File: tb/tb__piso_er.sv
// Directed bench for _piso_er: MSB/LSB order, backpressure, back-to-back, mid-word reset, n=1.
module tb__piso_er;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   _piso_er_if #(.N(8)) bm ();
   _piso_er_if #(.N(8)) bl ();
   _piso_er_if #(.N(1)) b1 ();

   _piso_er #(.n(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .io(bm));
   _piso_er #(.n(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .io(bl));
   _piso_er #(.n(1), .MSB_FIRST(1'b1)) u_n1  (.clk(clk), .rst(rst), .io(b1));

   task automatic chk(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic ser_msb(input string tag, input logic [7:0] word);
      logic [7:0] w;
      w = word;
      @(negedge clk);
      bm.ld_valid = 1'b1; bm.D = word; bm.sout_ready = 1'b1;
      #1 chk({tag, "_ldrdy_idle"}, bm.ld_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bm.ld_valid = 1'b0;
         #1;
         chk({tag, "_bit"},   bm.sout,       w[7]);
         chk({tag, "_vld"},   bm.sout_valid, 1'b1);
         chk({tag, "_done0"}, bm.done,       1'b0);
         chk({tag, "_ldrdy"}, bm.ld_ready,   i == 7);
         w = w << 1;
      end
      @(negedge clk); #1;
      chk({tag, "_done1"},    bm.done,       1'b1);
      chk({tag, "_vld_end"},  bm.sout_valid, 1'b0);
      chk({tag, "_busy_end"}, bm.busy,       1'b0);
      chk({tag, "_ldrdy_end"},bm.ld_ready,   1'b1);
      @(negedge clk); #1;
      chk({tag, "_done_drop"}, bm.done, 1'b0);
   endtask

   initial begin
      logic [7:0] w;
      int idx, ndone;
      logic rdy, exp_done;

      bm.ld_valid = 1'b0; bm.D = 8'h00; bm.sout_ready = 1'b0;
      bl.ld_valid = 1'b0; bl.D = 8'h00; bl.sout_ready = 1'b0;
      b1.ld_valid = 1'b0; b1.D = 1'b0;  b1.sout_ready = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_sout",  bm.sout,       1'b0);
      chk("rst_vld",   bm.sout_valid, 1'b0);
      chk("rst_busy",  bm.busy,       1'b0);
      chk("rst_done",  bm.done,       1'b0);
      chk("rst_ldrdy", bm.ld_ready,   1'b1);
      chk("rst_n1_vld", b1.sout_valid, 1'b0);
      rst = 1'b0;

      ser_msb("msb_a5", 8'hA5);

      // LSB-first: bit k of the word appears on beat k
      w = 8'hA5;
      @(negedge clk);
      bl.ld_valid = 1'b1; bl.D = w; bl.sout_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bl.ld_valid = 1'b0;
         #1;
         chk("lsb_bit", bl.sout,       w[0]);
         chk("lsb_vld", bl.sout_valid, 1'b1);
         w = w >> 1;
      end
      @(negedge clk); #1;
      chk("lsb_done", bl.done,       1'b1);
      chk("lsb_vld_end", bl.sout_valid, 1'b0);

      // Backpressure: ready 1,0,0,1,0,0,...
      w = 8'h6B;
      @(negedge clk);
      bm.ld_valid = 1'b1; bm.D = w; bm.sout_ready = 1'b0;
      idx = 0; ndone = 0; exp_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         bm.ld_valid = 1'b0;
         rdy = (c % 3 == 0);
         bm.sout_ready = rdy;
         #1;
         if (idx < 8) begin
            chk("bp_vld", bm.sout_valid, 1'b1);
            chk("bp_bit", bm.sout,       w[7]);
         end else begin
            chk("bp_vld_end", bm.sout_valid, 1'b0);
         end
         chk("bp_done", bm.done, exp_done);
         if (bm.done) ndone++;
         exp_done = (idx == 7) && rdy;
         if (idx < 8 && rdy) begin
            idx++;
            w = w << 1;
         end
      end
      chk("bp_ndone", ndone == 1, 1'b1);
      chk("bp_beats", idx == 8,   1'b1);

      // Back-to-back FF then 00 with ld_valid held
      @(negedge clk);
      bm.ld_valid = 1'b1; bm.D = 8'hFF; bm.sout_ready = 1'b1;
      ndone = 0;
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk);
         bm.ld_valid = (c <= 7);
         bm.D = (c >= 7) ? 8'h00 : 8'hFF;
         #1;
         if (c < 16) begin
            chk("b2b_vld",   bm.sout_valid, 1'b1);
            chk("b2b_bit",   bm.sout,       c < 8);
            chk("b2b_ldrdy", bm.ld_ready,   c == 7 || c == 15);
         end else begin
            chk("b2b_vld_end", bm.sout_valid, 1'b0);
         end
         chk("b2b_done", bm.done, c == 8 || c == 16);
         if (bm.done) ndone++;
      end
      chk("b2b_ndone", ndone == 2, 1'b1);
      bm.ld_valid = 1'b0;

      // Asynchronous reset after three beats of C3
      w = 8'hC3;
      @(negedge clk);
      bm.ld_valid = 1'b1; bm.D = w; bm.sout_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bm.ld_valid = 1'b0;
         #1 chk("rm_bit", bm.sout, w[7]);
         w = w << 1;
      end
      @(negedge clk);
      bm.sout_ready = 1'b0;
      #1 chk("rm_vld_pre", bm.sout_valid, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rm_sout", bm.sout,       1'b0);
      chk("rm_vld",  bm.sout_valid, 1'b0);
      chk("rm_busy", bm.busy,       1'b0);
      chk("rm_done", bm.done,       1'b0);
      #1 rst = 1'b0;
      ser_msb("rst_81", 8'h81);

      // n = 1: loads 1,0,1 back-to-back
      @(negedge clk);
      b1.ld_valid = 1'b1; b1.D = 1'b1; b1.sout_ready = 1'b1;
      #1 chk("n1_ldrdy_idle", b1.ld_ready, 1'b1);
      @(negedge clk);
      b1.D = 1'b0;
      #1;
      chk("n1_b0",     b1.sout,       1'b1);
      chk("n1_vld0",   b1.sout_valid, 1'b1);
      chk("n1_ldrdy0", b1.ld_ready,   1'b1);
      chk("n1_done0",  b1.done,       1'b0);
      @(negedge clk);
      b1.D = 1'b1;
      #1;
      chk("n1_b1",    b1.sout,       1'b0);
      chk("n1_vld1",  b1.sout_valid, 1'b1);
      chk("n1_done1", b1.done,       1'b1);
      @(negedge clk);
      b1.ld_valid = 1'b0;
      #1;
      chk("n1_b2",    b1.sout,       1'b1);
      chk("n1_done2", b1.done,       1'b1);
      @(negedge clk); #1;
      chk("n1_vld_end", b1.sout_valid, 1'b0);
      chk("n1_done3",   b1.done,       1'b1);
      @(negedge clk); #1;
      chk("n1_done_drop", b1.done, 1'b0);

      // n = 1: ld_ready follows sout_ready combinationally while shifting
      b1.ld_valid = 1'b1; b1.D = 1'b1; b1.sout_ready = 1'b0;
      @(negedge clk);
      b1.ld_valid = 1'b0;
      #1 chk("n1_ldrdy_stall", b1.ld_ready, 1'b0);
      b1.sout_ready = 1'b1;
      #1 chk("n1_ldrdy_go",    b1.ld_ready, 1'b1);
      @(negedge clk); #1;
      chk("n1_stall_done", b1.done,       1'b1);
      chk("n1_stall_idle", b1.sout_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
